// File: rtl/lc3_mem_arbiter.sv
// Two-port arbiter for the LC-3 memory bus. Port A (core) and port B (DMA/debug loader)
// share one memory port; one whole transaction is granted at a time, the bus is
// registered at grant, and each transaction ends with a one-cycle ack (err on timeout).
module lc3_mem_arbiter #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_rd,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  input  logic          b_req,
  input  logic          b_rd,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          mem_en,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] dout,
  input  logic          complete
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  // Last BUSY cycle index before abort; unused when TIMEOUT is 0.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;  // 0 = A, 1 = B
  logic          last_q, last_d;    // port granted most recently
  logic          mem_en_q, mem_en_d;
  logic          mem_rd_q, mem_rd_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          a_ack_q, a_ack_d;
  logic          b_ack_q, b_ack_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          pick_b;
  logic          timeout_hit;

  // B wins when it is the only requester, or on contention when A was served last.
  assign pick_b      = b_req && (!a_req || !last_q);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TimeoutLast);

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    mem_en_d   = mem_en_q;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    cnt_d      = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (a_req || b_req) begin
          owner_d    = pick_b;
          last_d     = pick_b;
          mem_rd_d   = pick_b ? b_rd    : a_rd;
          mem_addr_d = pick_b ? b_addr  : a_addr;
          mem_din_d  = pick_b ? b_wdata : a_wdata;
          mem_en_d   = 1'b1;
          cnt_d      = '0;
          state_d    = StBusy;
        end
      end
      StBusy: begin
        // complete takes priority over a coincident timeout.
        if (complete) begin
          if (mem_rd_q) rdata_d = dout;
          err_d    = 1'b0;
          mem_en_d = 1'b0;
          a_ack_d  = !owner_q;
          b_ack_d  = owner_q;
          state_d  = StDone;
        end else if (timeout_hit) begin
          err_d    = 1'b1;
          mem_en_d = 1'b0;
          a_ack_d  = !owner_q;
          b_ack_d  = owner_q;
          state_d  = StDone;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous reset; reset abandons any transaction without ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      mem_en_q   <= 1'b0;
      mem_rd_q   <= 1'b1;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      mem_en_q   <= mem_en_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      cnt_q      <= cnt_d;
    end
  end

  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;
  assign rdata    = rdata_q;
  assign err      = err_q;
  assign mem_en   = mem_en_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Scoreboard bench for lc3_mem_arbiter: stimulus pushes expected grants and acks into
// queues; independent monitors pop and compare when the DUT raises mem_en or an ack.
module tb_lc3_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_req, a_rd, b_req, b_rd;
  logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_ack, b_ack, err, mem_en, mem_rd, complete;
  logic [15:0] rdata, mem_addr, mem_din, dout;

  lc3_mem_arbiter #(
    .AW      (16),
    .DW      (16),
    .TIMEOUT (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .a_req    (a_req),
    .a_rd     (a_rd),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_ack    (a_ack),
    .b_req    (b_req),
    .b_rd     (b_rd),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_ack    (b_ack),
    .rdata    (rdata),
    .err      (err),
    .mem_en   (mem_en),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .dout     (dout),
    .complete (complete)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rd;
    logic [15:0] addr;
    logic [15:0] din;
  } bus_t;

  typedef struct {
    logic        port;
    logic [15:0] rdata;
    logic        err;
  } ack_t;

  bus_t exp_bus[$];
  ack_t exp_ack[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event did not match expectation", name);
  endtask

  // Memory model: complete in the mem_lat-th BUSY cycle unless hung.
  logic [15:0] mem [logic [15:0]];
  int  mem_lat  = 2;
  bit  mem_hang = 1'b0;
  bit  stray    = 1'b0;
  int  busy_cnt = 0;

  always @(negedge clock) begin
    if (mem_en) begin
      busy_cnt++;
      if (!mem_hang && busy_cnt == mem_lat) begin
        complete = 1'b1;
        if (mem_rd) dout = mem.exists(mem_addr) ? mem[mem_addr] : 16'hDEAD;
        else begin
          mem[mem_addr] = mem_din;
          dout = 16'h0BAD;
        end
      end else begin
        complete = 1'b0;
        dout     = 16'h5A5A;
      end
    end else begin
      busy_cnt = 0;
      complete = stray;
      dout     = 16'h7777;
    end
  end

  // Bus monitor: grant order and contents, stability while mem_en, access length.
  bit          prev_en = 1'b0;
  int          en_len = 0;
  int          last_len = 0;
  bus_t        snap;
  always @(negedge clock) begin
    bus_t e;
    if (mem_en && !prev_en) begin
      en_len = 1;
      snap.rd = mem_rd; snap.addr = mem_addr; snap.din = mem_din;
      if (exp_bus.size() == 0) fail_now("unexpected_grant");
      else begin
        e = exp_bus.pop_front();
        check("grant_rd", mem_rd, e.rd);
        check("grant_addr", mem_addr, e.addr);
        if (!e.rd) check("grant_din", mem_din, e.din);
      end
    end else if (mem_en) begin
      en_len++;
      check("stable_rd", mem_rd, snap.rd);
      check("stable_addr", mem_addr, snap.addr);
      check("stable_din", mem_din, snap.din);
    end else if (prev_en) begin
      last_len = en_len;
    end
    if (a_ack || b_ack) check("single_ack", a_ack & b_ack, 0);
    prev_en = mem_en;
  end

  // Ack monitor.
  int acks_seen = 0;
  always @(negedge clock) begin
    ack_t e;
    if (a_ack || b_ack) begin
      acks_seen++;
      if (exp_ack.size() == 0) fail_now("unexpected_ack");
      else begin
        e = exp_ack.pop_front();
        check("ack_port", b_ack, e.port);
        check("ack_rdata", rdata, e.rdata);
        check("ack_err", err, e.err);
      end
    end
  end

  task automatic expect_xact(input logic port, input logic rd, input logic [15:0] addr,
                             input logic [15:0] din, input logic [15:0] rd_data,
                             input logic e_err);
    bus_t b;
    ack_t a;
    b.rd = rd; b.addr = addr; b.din = din;
    a.port = port; a.rdata = rd_data; a.err = e_err;
    exp_bus.push_back(b);
    exp_ack.push_back(a);
  endtask

  // Issue one transaction on a port; keep leaves req high for a follow-on request.
  task automatic xact(input logic port, input logic rd, input logic [15:0] addr,
                      input logic [15:0] wdata, input bit keep);
    bit got = 1'b0;
    if (!port) begin
      a_rd = rd; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
    end else begin
      b_rd = rd; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if ((!port && a_ack) || (port && b_ack)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now(port ? "b_ack_timeout" : "a_ack_timeout");
    if (!keep) begin
      if (!port) a_req = 1'b0;
      else b_req = 1'b0;
    end
  endtask

  task automatic wait_mem_en();
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (mem_en) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("mem_en_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_before;
    reset = 1'b1;
    a_req = 0; a_rd = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_rd = 0; b_addr = 0; b_wdata = 0;
    complete = 0; dout = 0;
    mem[16'h3000] = 16'h1234;
    mem[16'h3001] = 16'h1111;
    mem[16'h3002] = 16'h2222;
    mem[16'h6001] = 16'hB001;
    mem[16'h6002] = 16'hB002;

    repeat (3) @(negedge clock);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_rd", mem_rd, 1);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_rdata", rdata, 0);
    check("rst_a_ack", a_ack, 0);
    check("rst_b_ack", b_ack, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    @(negedge clock);

    // Contention after reset: A first, then strict alternation on sustained requests.
    expect_xact(0, 1, 16'h3001, 0, 16'h1111, 0);
    expect_xact(1, 1, 16'h6001, 0, 16'hB001, 0);
    expect_xact(0, 1, 16'h3002, 0, 16'h2222, 0);
    expect_xact(1, 1, 16'h6002, 0, 16'hB002, 0);
    fork
      begin
        xact(0, 1, 16'h3001, 0, 1);
        xact(0, 1, 16'h3002, 0, 0);
      end
      begin
        xact(1, 1, 16'h6001, 0, 1);
        xact(1, 1, 16'h6002, 0, 0);
      end
    join
    @(negedge clock);

    // Single A read.
    mem_lat = 2;
    expect_xact(0, 1, 16'h3000, 0, 16'h1234, 0);
    xact(0, 1, 16'h3000, 0, 0);
    @(negedge clock);
    check("a_ack_one_cycle", a_ack, 0);
    check("rdata_held", rdata, 16'h1234);

    // B write leaves rdata untouched; A reads it back.
    expect_xact(1, 0, 16'h4000, 16'hBEEF, 16'h1234, 0);
    xact(1, 0, 16'h4000, 16'hBEEF, 0);
    expect_xact(0, 1, 16'h4000, 0, 16'hBEEF, 0);
    xact(0, 1, 16'h4000, 0, 0);
    @(negedge clock);

    // Hung access aborts after 4 BUSY cycles; rdata keeps the previous read.
    mem_hang = 1'b1;
    expect_xact(0, 1, 16'h3000, 0, 16'hBEEF, 1);
    xact(0, 1, 16'h3000, 0, 0);
    @(negedge clock);
    check("timeout_len", last_len, 4);
    mem_hang = 1'b0;
    expect_xact(1, 1, 16'h6001, 0, 16'hB001, 0);
    xact(1, 1, 16'h6001, 0, 0);
    // complete on the last allowed BUSY cycle finishes normally.
    mem_lat = 4;
    expect_xact(0, 1, 16'h3001, 0, 16'h1111, 0);
    xact(0, 1, 16'h3001, 0, 0);
    @(negedge clock);
    check("limit_len", last_len, 4);

    // Requester inputs changing after grant do not reach the bus.
    mem_lat = 3;
    expect_xact(0, 1, 16'h3002, 0, 16'h2222, 0);
    fork
      xact(0, 1, 16'h3002, 0, 0);
      begin
        wait_mem_en();
        a_addr = 16'h5555; a_wdata = 16'hFFFF; a_rd = 1'b0;
      end
    join
    @(negedge clock);

    // Stray complete while idle.
    ack_before = acks_seen;
    @(posedge clock); #1 stray = 1'b1;
    @(posedge clock); #1 stray = 1'b0;
    repeat (5) @(negedge clock);
    check("stray_no_ack", acks_seen, ack_before);
    check("stray_no_en", mem_en, 0);

    // Reset while BUSY: abandon, no ack, reset values, A wins next contention.
    exp_bus.push_back('{rd: 1'b1, addr: 16'h3000, din: 16'h0000});
    a_rd = 1'b1; a_addr = 16'h3000; a_wdata = 0; a_req = 1'b1;
    wait_mem_en();
    reset = 1'b1;
    a_req = 1'b0;
    @(negedge clock);
    check("rstbusy_mem_en", mem_en, 0);
    check("rstbusy_a_ack", a_ack, 0);
    check("rstbusy_b_ack", b_ack, 0);
    check("rstbusy_mem_rd", mem_rd, 1);
    check("rstbusy_mem_addr", mem_addr, 0);
    check("rstbusy_rdata", rdata, 0);
    check("rstbusy_err", err, 0);
    reset = 1'b0;
    @(negedge clock);
    expect_xact(0, 1, 16'h3000, 0, 16'h1234, 0);
    expect_xact(1, 1, 16'h6002, 0, 16'hB002, 0);
    fork
      xact(0, 1, 16'h3000, 0, 0);
      xact(1, 1, 16'h6002, 0, 0);
    join

    repeat (4) @(negedge clock);
    check("ack_queue_drained", exp_ack.size(), 0);
    check("bus_queue_drained", exp_bus.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
